adiw_sbiw_seq: RTL and testbench

//  Two-cycle sequencer for the AVR ADIW/SBIW word instructions (pairs R25:24..R31:30).

---
 rtl/adiw_sbiw_seq_pkg.sv | 21 ++
 rtl/adiw_sbiw_seq_flag_calc.sv | 28 ++
 rtl/adiw_sbiw_seq.sv | 96 +++++++++
 tb/tb_adiw_sbiw_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/adiw_sbiw_seq_pkg.sv
// Shared types and helpers for the ADIW/SBIW word-op sequencer.
package adiw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } adiw_state_e;

  localparam int SREG_C = 0;
  localparam int SREG_Z = 1;
  localparam int SREG_N = 2;
  localparam int SREG_V = 3;
  localparam int SREG_S = 4;

  // Low register index of the selected pair (pairs are two registers apart).
  function automatic logic [4:0] pair_addr(input logic [1:0] sel, input int base);
    return 5'(base + 2 * int'(sel));
  endfunction

endpackage

// File: rtl/adiw_sbiw_seq_flag_calc.sv
// SREG flag generation for the ADIW/SBIW result word.
module adiw_flag_calc
  import adiw_pkg::*;
(
  input  logic        rdh7_i,
  input  logic [15:0] res_i,
  input  logic        co_i,
  input  logic        sub_i,
  output logic [4:0]  sreg_o
);

  logic n, z, c, v;

  always_comb begin
    n = res_i[15];
    z = (res_i == 16'h0000);
    // SBIW runs as A + ~K + 1, so the adder carry is the inverse of the borrow.
    c = sub_i ? ~co_i : co_i;
    v = sub_i ? (rdh7_i & ~res_i[15]) : (~rdh7_i & res_i[15]);
    sreg_o         = '0;
    sreg_o[SREG_N] = n;
    sreg_o[SREG_Z] = z;
    sreg_o[SREG_C] = c;
    sreg_o[SREG_V] = v;
    sreg_o[SREG_S] = n ^ v;
  end

endmodule

// File: rtl/adiw_sbiw_seq.sv
// Two-cycle ADIW/SBIW sequencer: drives the external 16-bit adder, captures
// its result and emits the register-pair write plus SREG update.
module adiw_sbiw_seq
  import adiw_pkg::*;
#(
  parameter int PAIR_BASE = 24,
  parameter int K_W       = 6
) (
  input  logic           cp2,
  input  logic           ireset,
  input  logic           hold_i,
  input  logic           kill_i,
  input  logic           start_i,
  input  logic           sub_i,
  input  logic [1:0]     pair_sel_i,
  input  logic [K_W-1:0] k_i,
  input  logic [15:0]    rd_pair_i,
  output logic [15:0]    add_a_o,
  output logic [15:0]    add_b_o,
  output logic           add_ci_o,
  input  logic [15:0]    add_s_i,
  input  logic           add_co_i,
  output logic           busy_o,
  output logic           wr_en_o,
  output logic [4:0]     wr_addr_o,
  output logic [15:0]    wr_data_o,
  output logic           sreg_we_o,
  output logic [4:0]     sreg_o
);

  adiw_state_e    state_q;
  logic           sub_q;
  logic [1:0]     sel_q;
  logic [K_W-1:0] k_q;
  logic [15:0]    rd_q;
  logic [15:0]    r_q;
  logic           co_q;
  logic [4:0]     flags;
  logic [15:0]    k_ext;
  logic           in_exec, in_wb;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_q <= IDLE;
      sub_q   <= 1'b0;
      sel_q   <= '0;
      k_q     <= '0;
      rd_q    <= '0;
      r_q     <= '0;
      co_q    <= 1'b0;
    end else if (kill_i) begin
      state_q <= IDLE;
    end else if (!hold_i) begin
      case (state_q)
        IDLE: if (start_i) begin
          sub_q   <= sub_i;
          sel_q   <= pair_sel_i;
          k_q     <= k_i;
          rd_q    <= rd_pair_i;
          state_q <= EXEC;
        end
        EXEC: begin
          r_q     <= add_s_i;
          co_q    <= add_co_i;
          state_q <= WB;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  adiw_flag_calc u_flags (
    .rdh7_i (rd_q[15]),
    .res_i  (r_q),
    .co_i   (co_q),
    .sub_i  (sub_q),
    .sreg_o (flags)
  );

  assign in_exec = (state_q == EXEC);
  assign in_wb   = (state_q == WB);
  assign k_ext   = 16'(k_q);

  // Adder sees zeros outside EXEC so it does not toggle on idle cycles.
  assign add_a_o  = in_exec ? rd_q : '0;
  assign add_b_o  = in_exec ? (sub_q ? ~k_ext : k_ext) : '0;
  assign add_ci_o = in_exec & sub_q;

  assign busy_o    = (state_q != IDLE);
  assign wr_en_o   = in_wb & ~kill_i;
  assign sreg_we_o = in_wb & ~kill_i;
  assign wr_addr_o = in_wb ? pair_addr(sel_q, PAIR_BASE) : '0;
  assign wr_data_o = in_wb ? r_q : '0;
  assign sreg_o    = in_wb ? flags : '0;

endmodule

// File: tb/tb_adiw_sbiw_seq.sv
// Directed and randomized checks of the ADIW/SBIW sequencer with a behavioural adder.
module tb_adiw_sbiw_seq;

  logic        cp2 = 1'b0;
  logic        ireset = 1'b0;
  logic        hold_i = 1'b0, kill_i = 1'b0, start_i = 1'b0, sub_i = 1'b0;
  logic [1:0]  pair_sel_i = '0;
  logic [5:0]  k_i = '0;
  logic [15:0] rd_pair_i = '0;
  logic [15:0] add_a_o, add_b_o, add_s_i, wr_data_o;
  logic        add_ci_o, add_co_i, busy_o, wr_en_o, sreg_we_o;
  logic [4:0]  wr_addr_o, sreg_o;

  int errs = 0;
  int checks = 0;

  adiw_sbiw_seq #(.PAIR_BASE(24), .K_W(6)) dut (
    .cp2(cp2), .ireset(ireset), .hold_i(hold_i), .kill_i(kill_i),
    .start_i(start_i), .sub_i(sub_i), .pair_sel_i(pair_sel_i), .k_i(k_i),
    .rd_pair_i(rd_pair_i), .add_a_o(add_a_o), .add_b_o(add_b_o),
    .add_ci_o(add_ci_o), .add_s_i(add_s_i), .add_co_i(add_co_i),
    .busy_o(busy_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .sreg_we_o(sreg_we_o), .sreg_o(sreg_o)
  );

  // External CLA stand-in
  assign {add_co_i, add_s_i} = {1'b0, add_a_o} + {1'b0, add_b_o} + 17'(add_ci_o);

  always #5 cp2 = ~cp2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge cp2);
    #1;
  endtask

  task automatic issue(input logic sub, input logic [1:0] sel, input logic [5:0] k,
                       input logic [15:0] pair);
    start_i = 1'b1; sub_i = sub; pair_sel_i = sel; k_i = k; rd_pair_i = pair;
    tick();
    start_i = 1'b0; sub_i = 1'b0; pair_sel_i = '0; k_i = '0; rd_pair_i = '0;
  endtask

  // Full op with no stalls; checks EXEC cycle, WB strobe contents, and return to IDLE.
  task automatic run_op(input string tag, input logic sub, input logic [1:0] sel,
                        input logic [5:0] k, input logic [15:0] pair,
                        input logic [4:0] e_addr, input logic [15:0] e_data,
                        input logic [4:0] e_sreg);
    issue(sub, sel, k, pair);
    chk({tag, ".exec_busy"}, busy_o, 1);
    chk({tag, ".exec_wr"}, wr_en_o, 0);
    chk({tag, ".exec_a"}, add_a_o, pair);
    tick();
    chk({tag, ".wr_en"}, {sreg_we_o, wr_en_o}, 2'b11);
    chk({tag, ".addr"}, wr_addr_o, e_addr);
    chk({tag, ".data"}, wr_data_o, e_data);
    chk({tag, ".sreg"}, sreg_o, e_sreg);
    tick();
    chk({tag, ".idle"}, {busy_o, wr_en_o}, 2'b00);
  endtask

  initial begin
    logic        rs;
    logic [1:0]  rsel;
    logic [5:0]  rk;
    logic [15:0] rp, rr;
    logic        rc, rv;
    logic [16:0] sum;

    // Reset state
    #12;
    chk("rst.busy", busy_o, 0);
    chk("rst.wr", {wr_en_o, sreg_we_o}, 0);
    chk("rst.add", {add_a_o, add_b_o, add_ci_o}, 0);
    chk("rst.out", {wr_addr_o, wr_data_o, sreg_o}, 0);
    @(negedge cp2);
    ireset = 1'b1;
    tick();

    // Directed arithmetic vectors
    run_op("adiw_00ff", 0, 2'd0, 6'd1,  16'h00FF, 5'd24, 16'h0100, 5'b00000);
    run_op("adiw_ffff", 0, 2'd3, 6'd1,  16'hFFFF, 5'd30, 16'h0000, 5'b00011);
    run_op("sbiw_0000", 1, 2'd1, 6'd1,  16'h0000, 5'd26, 16'hFFFF, 5'b10101);
    run_op("adiw_7fff", 0, 2'd2, 6'd1,  16'h7FFF, 5'd28, 16'h8000, 5'b01100);
    run_op("sbiw_8000", 1, 2'd2, 6'd1,  16'h8000, 5'd28, 16'h7FFF, 5'b11000);
    run_op("adiw_k0",   0, 2'd1, 6'd0,  16'h1234, 5'd26, 16'h1234, 5'b00000);
    run_op("sbiw_k0z",  1, 2'd0, 6'd0,  16'h0000, 5'd24, 16'h0000, 5'b00010);
    run_op("adiw_k63",  0, 2'd3, 6'd63, 16'hFFC1, 5'd30, 16'h0000, 5'b00011);

    // EXEC B/CI drive for SBIW
    issue(1, 2'd0, 6'd5, 16'h0100);
    chk("sbiw.b", add_b_o, 16'hFFFA);
    chk("sbiw.ci", add_ci_o, 1);
    tick(); tick();

    // Kill in EXEC: no strobe
    issue(0, 2'd0, 6'd3, 16'h0010);
    kill_i = 1'b1;
    #1 chk("kill_exec.wr", wr_en_o, 0);
    tick();
    kill_i = 1'b0;
    chk("kill_exec.busy", busy_o, 0);
    tick();
    chk("kill_exec.nowr", wr_en_o, 0);

    // Kill in WB suppresses the strobe combinationally
    issue(0, 2'd0, 6'd3, 16'h0010);
    tick();
    chk("kill_wb.pre", wr_en_o, 1);
    kill_i = 1'b1;
    #1 chk("kill_wb.wr", {wr_en_o, sreg_we_o}, 2'b00);
    tick();
    kill_i = 1'b0;
    chk("kill_wb.idle", busy_o, 0);

    // Kill together with start in IDLE drops the start
    kill_i = 1'b1;
    issue(0, 2'd1, 6'd2, 16'h0002);
    kill_i = 1'b0;
    chk("kill_start.busy", busy_o, 0);

    // Second start while busy is ignored
    issue(0, 2'd1, 6'd2, 16'h0100);
    start_i = 1'b1; sub_i = 1'b1; pair_sel_i = 2'd3; k_i = 6'd9; rd_pair_i = 16'hAAAA;
    tick();
    start_i = 1'b0;
    chk("busy_start.data", wr_data_o, 16'h0102);
    chk("busy_start.addr", wr_addr_o, 5'd26);
    tick();
    chk("busy_start.idle", busy_o, 0);

    // Hold 3 cycles in EXEC delays the strobe by exactly 3
    issue(1, 2'd2, 6'd4, 16'h0010);
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_exec.wr", {busy_o, wr_en_o}, 2'b10);
    end
    hold_i = 1'b0;
    tick();
    chk("hold_exec.wr_en", wr_en_o, 1);
    chk("hold_exec.data", wr_data_o, 16'h000C);
    // Hold in WB keeps the strobe up, then releases to IDLE
    hold_i = 1'b1;
    tick();
    chk("hold_wb.wr", wr_en_o, 1);
    hold_i = 1'b0;
    tick();
    chk("hold_wb.idle", {busy_o, wr_en_o}, 2'b00);

    // Async reset during EXEC
    issue(0, 2'd3, 6'd7, 16'h1234);
    #2 ireset = 1'b0;
    #1;
    chk("rst_exec.busy", busy_o, 0);
    chk("rst_exec.add", {add_a_o, add_b_o, add_ci_o}, 0);
    chk("rst_exec.wr", {wr_en_o, sreg_we_o}, 0);
    @(negedge cp2);
    ireset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_exec.nowr", {busy_o, wr_en_o}, 2'b00);
    end

    // Random ops against a borrow/carry reference model
    for (int n = 0; n < 24; n++) begin
      rs   = 1'($urandom_range(0, 1));
      rsel = 2'($urandom_range(0, 3));
      rk   = 6'($urandom_range(0, 63));
      rp   = (n < 4) ? 16'hFFFF - 16'(n) : 16'($urandom);
      if (rs) begin
        rr = rp - 16'(rk);
        rc = (16'(rk) > rp);
        rv = rp[15] & ~rr[15];
      end else begin
        sum = 17'(rp) + 17'(rk);
        rr = sum[15:0];
        rc = sum[16];
        rv = ~rp[15] & rr[15];
      end
      run_op("rand", rs, rsel, rk, rp, 5'(24 + 2 * int'(rsel)), rr,
             {rr[15] ^ rv, rv, rr[15], rr == 16'h0000, rc});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
